clause_check_sequencer: RTL

- Controller for the unsatisfied-clause checker datapath.
- Streams N = 2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX clauses into the clause registers.
- Fires all per-clause checkers, collects their ready flags, and samples the tree's satisfied result.
- Formula satisfied: stops. Otherwise: hands the selected unsatisfied clause to the stochastic-move stage, then re-checks, up to an iteration budget.

---
 rtl/clause_seq_pkg.sv | 17 +
 rtl/ready_collector.sv | 30 +++
 rtl/clause_check_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/clause_seq_pkg.sv
// Shared state encoding and default sizing for the clause-check sequencer.
package clause_seq_pkg;

  localparam int CLAUSE_IDX_W = 2;
  localparam int N = 2**CLAUSE_IDX_W;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOAD        = 3'd1,
    CHECK_ISSUE = 3'd2,
    CHECK_WAIT  = 3'd3,
    DECIDE      = 3'd4,
    MOVE        = 3'd5,
    DONE        = 3'd6
  } state_t;

endpackage

// File: rtl/ready_collector.sv
// Sticky OR of per-clause checker ready flags; all_ready also counts flags
// arriving in the current cycle so a last-cycle pulse completes the set.
module ready_collector
  import clause_seq_pkg::*;
#(
  parameter int WIDTH = N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             collect,
  input  logic [WIDTH-1:0] ready,
  output logic             all_ready
);

  logic [WIDTH-1:0] sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else if (clear) begin
      sticky_q <= '0;
    end else if (collect) begin
      sticky_q <= sticky_q | ready;
    end
  end

  assign all_ready = &(sticky_q | ready);

endmodule

// File: rtl/clause_check_sequencer.sv
// Load / check / move controller for the unsatisfied-clause checker datapath.
// Optional CHECK_WAIT watchdog enabled by CLAUSE_SEQ_CHECK_TIMEOUT_EN.
module clause_check_sequencer
  import clause_seq_pkg::*;
#(
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = CLAUSE_IDX_W,
  parameter int MAXIMUM_BIT_WIDTH_OF_ITERATIONS    = 8,
  parameter int CHECK_TIMEOUT_CYCLES               = 64
) (
  input  logic                                          in_clk,
  input  logic                                          in_reset,
  input  logic                                          in_start,
  input  logic                                          in_reload,
  input  logic [MAXIMUM_BIT_WIDTH_OF_ITERATIONS-1:0]    in_max_iterations,
  input  logic                                          in_load_valid,
  output logic                                          out_load_ready,
  output logic                                          out_load_write,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_index,
  output logic [2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_checker_enable,
  input  logic [2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] in_checker_ready,
  input  logic                                          in_satisfied,
  output logic                                          out_move_valid,
  input  logic                                          in_move_ready,
  output logic [MAXIMUM_BIT_WIDTH_OF_ITERATIONS-1:0]    out_iteration_count,
  output logic                                          out_busy,
  output logic                                          out_done,
  output logic                                          out_solved,
  output logic                                          out_error
);

  localparam int IW  = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int NC  = 2**IW;
  localparam int ITW = MAXIMUM_BIT_WIDTH_OF_ITERATIONS;
  localparam logic [IW-1:0] LAST_IDX = '1;

  state_t          state_q, state_d;
  logic [IW-1:0]   clause_idx_q;
  logic [ITW-1:0]  iter_q;
  logic            sat_q;
  logic            solved_q;
  logic            load_ready;
  logic [NC-1:0]   checker_en;
  logic            move_valid;
  logic            sticky_clear;
  logic            collect;
  logic            all_ready;
  logic            timeout_hit;
  logic            budget_spent;

  ready_collector #(.WIDTH(NC)) u_ready_collector (
    .clk       (in_clk),
    .rst_n     (in_reset),
    .clear     (sticky_clear),
    .collect   (collect),
    .ready     (in_checker_ready),
    .all_ready (all_ready)
  );

  // A zero budget means unlimited; a saturated counter then never matches.
  assign budget_spent = (in_max_iterations != '0) && (iter_q == in_max_iterations);

  always_comb begin
    state_d      = state_q;
    load_ready   = 1'b0;
    checker_en   = '0;
    move_valid   = 1'b0;
    sticky_clear = 1'b0;
    collect      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_start) state_d = LOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        if (in_load_valid && (clause_idx_q == LAST_IDX)) state_d = CHECK_ISSUE;
      end
      CHECK_ISSUE: begin
        checker_en   = '1;
        sticky_clear = 1'b1;
        state_d      = CHECK_WAIT;
      end
      CHECK_WAIT: begin
        collect = 1'b1;
        if (all_ready) state_d = DECIDE;
        else if (timeout_hit) state_d = DONE;
      end
      DECIDE: begin
        state_d = (sat_q || budget_spent) ? DONE : MOVE;
      end
      MOVE: begin
        move_valid = 1'b1;
        if (in_move_ready) state_d = CHECK_ISSUE;
      end
      DONE: begin
        if (in_start) state_d = in_reload ? LOAD : CHECK_ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q      <= IDLE;
      clause_idx_q <= '0;
      iter_q       <= '0;
      sat_q        <= 1'b0;
      solved_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_start) begin
            clause_idx_q <= '0;
            iter_q       <= '0;
          end
        end
        LOAD: begin
          if (in_load_valid) clause_idx_q <= clause_idx_q + IW'(1);
        end
        CHECK_WAIT: begin
          if (all_ready) sat_q <= in_satisfied;
        end
        DECIDE: begin
          if (sat_q) solved_q <= 1'b1;
        end
        MOVE: begin
          if (in_move_ready && (iter_q != '1)) iter_q <= iter_q + ITW'(1);
        end
        DONE: begin
          if (in_start) begin
            clause_idx_q <= '0;
            iter_q       <= '0;
            solved_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CLAUSE_SEQ_CHECK_TIMEOUT_EN
  localparam int WD_W = $clog2(CHECK_TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            error_q;

  // Fires on the last permitted CHECK_WAIT cycle; a completing ready wins.
  assign timeout_hit = (state_q == CHECK_WAIT) &&
                       (wd_q == WD_W'(CHECK_TIMEOUT_CYCLES - 1));

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      if (state_q == CHECK_ISSUE) wd_q <= '0;
      else if (state_q == CHECK_WAIT) wd_q <= wd_q + WD_W'(1);
      if (timeout_hit && !all_ready) error_q <= 1'b1;
      else if ((state_q == DONE) && in_start) error_q <= 1'b0;
    end
  end

  assign out_error = error_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (CHECK_TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign out_error          = 1'b0;
`endif

  assign out_load_ready      = load_ready;
  assign out_load_write      = in_load_valid & load_ready;
  assign out_clause_index    = clause_idx_q;
  assign out_checker_enable  = checker_en;
  assign out_move_valid      = move_valid;
  assign out_iteration_count = iter_q;
  assign out_busy            = (state_q != IDLE) && (state_q != DONE);
  assign out_done            = (state_q == DONE);
  assign out_solved          = solved_q;

endmodule
